// File: rtl/odometer_display_pkg.sv
// Shared constants, converter state encoding and segment decoder for the odometer display.
package odometer_display_pkg;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned IN_W   = 27;
  localparam int unsigned BCD_W  = 4 * DIGITS;

  localparam logic [IN_W-1:0] ODO_MAX = 27'd99_999_999;

  // {a,b,c,d,e,f,g,dp}, active-high
  localparam logic [7:0] SEG_0 = 8'hFC;
  localparam logic [7:0] SEG_1 = 8'h60;
  localparam logic [7:0] SEG_2 = 8'hDA;
  localparam logic [7:0] SEG_3 = 8'hF2;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'hB6;
  localparam logic [7:0] SEG_6 = 8'hBE;
  localparam logic [7:0] SEG_7 = 8'hE0;
  localparam logic [7:0] SEG_8 = 8'hFE;
  localparam logic [7:0] SEG_9 = 8'hF6;

  typedef enum logic [1:0] {StIdle, StShift, StDone} conv_state_e;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/odometer_display_if.sv
// Odometer value in, multiplexed display pins and BCD observability out.
interface odometer_display_if;
  import odometer_display_pkg::*;

  logic              power_now;
  logic [IN_W-1:0]   record;
  logic [DIGITS-1:0] seg_en;
  logic [7:0]        seg_out;
  logic [BCD_W-1:0]  bcd;
  logic              bcd_valid;

  modport master (
    output power_now, record,
    input  seg_en, seg_out, bcd, bcd_valid
  );

  modport slave (
    input  power_now, record,
    output seg_en, seg_out, bcd, bcd_valid
  );

endinterface

// File: rtl/odometer_display_bin2bcd_seq.sv
// Iterative double-dabble: one load cycle, IN_W shift cycles, one result cycle.
module bin2bcd_seq
  import odometer_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  bin,
  output logic             busy,
  output logic [BCD_W-1:0] bcd,
  output logic             valid
);

  localparam int unsigned SR_W  = BCD_W + IN_W;
  localparam int unsigned CNT_W = $clog2(IN_W + 1);

  conv_state_e      state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d, adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    adj     = sr_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (sr_q[IN_W+4*i +: 4] >= 4'd5) adj[IN_W+4*i +: 4] = sr_q[IN_W+4*i +: 4] + 4'd3;
    end
    case (state_q)
      StIdle: begin
        if (start) begin
          sr_d    = {{BCD_W{1'b0}}, bin};
          cnt_d   = CNT_W'(IN_W);
          state_d = StShift;
        end
      end
      StShift: begin
        sr_d  = {adj[SR_W-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = StDone;
      end
      StDone: begin
        bcd_d   = sr_q[SR_W-1 -: BCD_W];
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign bcd   = bcd_q;
  assign valid = valid_q;

endmodule

// File: rtl/odometer_display.sv
// Odometer display top: clamp, change detect, BCD conversion, digit scan with leading-zero blanking.
module odometer_display
  import odometer_display_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned SCAN_HZ  = 1_000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic               clk,
  input  logic               rst,
  odometer_display_if.slave  bus
);

  localparam int unsigned PRESCALE = CLK_HZ / SCAN_HZ;
  localparam int unsigned PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IDX_W    = $clog2(DIGITS);

  logic [IN_W-1:0]   clamped, last_q, last_d;
  logic              force_q, force_d;
  logic              start, busy, accept;
  logic [BCD_W-1:0]  bcd_val;
  logic              bcd_valid;
  logic [PS_W-1:0]   ps_q, ps_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] seg_en_q, seg_en_d;
  logic [7:0]        seg_out_q, seg_out_d;
  logic              lit;

  assign clamped = (bus.record > ODO_MAX) ? ODO_MAX : bus.record;
  assign start   = force_q | (clamped != last_q);
  assign accept  = start & ~busy;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (clamped),
    .busy  (busy),
    .bcd   (bcd_val),
    .valid (bcd_valid)
  );

  always_comb begin
    last_d    = last_q;
    force_d   = force_q;
    ps_d      = ps_q + 1'b1;
    idx_d     = idx_q;
    seg_en_d  = '0;
    seg_out_d = 8'h00;
    if (accept) begin
      last_d  = clamped;
      force_d = 1'b0;
    end
    if (ps_q == PS_W'(PRESCALE - 1)) begin
      ps_d  = '0;
      idx_d = idx_q + 1'b1;
    end
    // A digit is lit when it or any more significant digit is non-zero; digit 0 always lit.
    lit = (idx_q == '0) || (BLANK_LZ == 0) || ((bcd_val >> {idx_q, 2'b00}) != '0);
    if (bus.power_now && lit) begin
      seg_en_d  = DIGITS'(1) << idx_q;
      seg_out_d = seg_decode(bcd_val[{idx_q, 2'b00} +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= '0;
      force_q   <= 1'b1;
      ps_q      <= '0;
      idx_q     <= '0;
      seg_en_q  <= '0;
      seg_out_q <= 8'h00;
    end else begin
      last_q    <= last_d;
      force_q   <= force_d;
      ps_q      <= ps_d;
      idx_q     <= idx_d;
      seg_en_q  <= seg_en_d;
      seg_out_q <= seg_out_d;
    end
  end

  assign bus.seg_en    = seg_en_q;
  assign bus.seg_out   = seg_out_q;
  assign bus.bcd       = bcd_val;
  assign bus.bcd_valid = bcd_valid;

endmodule

// File: tb/tb_odometer_display.sv
// Bench: arithmetic reference model checked every cycle, plus directed literal checks.
module tb_odometer_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        power_now = 1'b1;
  logic [26:0] record = '0;

  always #5 clk = ~clk;

  odometer_display_if bus_a ();
  odometer_display_if bus_b ();

  assign bus_a.power_now = power_now;
  assign bus_a.record    = record;
  assign bus_b.power_now = power_now;
  assign bus_b.record    = record;

  odometer_display #(.CLK_HZ(1000), .SCAN_HZ(250), .BLANK_LZ(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  odometer_display #(.CLK_HZ(1000), .SCAN_HZ(250), .BLANK_LZ(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] seg_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                               8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned pow10(input int unsigned e);
    int unsigned r = 1;
    for (int i = 0; i < int'(e); i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int unsigned n);
    logic [31:0] r = '0;
    int unsigned v = n;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference model: conversion takes 28 edges after acceptance; display scans one digit
  // per 4 cycles, lit digits decided from the displayed number's magnitude.
  logic [31:0] m_bcd;
  int unsigned m_num, m_last, m_val, m_cyc, m_dig, m_idx, m_in;
  bit          m_force, m_busy, m_init = 1'b0, m_lit;
  int          m_rem;
  logic        m_valid;
  logic [7:0]  m_en_a, m_out_a, m_en_b, m_out_b;

  always @(posedge clk) begin
    if (rst) begin
      m_bcd = '0; m_num = 0; m_last = 0; m_force = 1'b1; m_busy = 1'b0; m_rem = 0;
      m_valid = 1'b0; m_cyc = 0;
      m_en_a = '0; m_out_a = '0; m_en_b = '0; m_out_b = '0;
      m_init = 1'b1;
    end else begin
      m_idx = (m_cyc / 4) % 8;
      m_dig = (m_num / pow10(m_idx)) % 10;
      m_lit = (m_idx == 0) || (m_num >= pow10(m_idx));
      m_en_a  = (power_now && m_lit) ? 8'(1 << m_idx) : 8'h00;
      m_out_a = (power_now && m_lit) ? seg_tab[m_dig] : 8'h00;
      m_en_b  = power_now ? 8'(1 << m_idx) : 8'h00;
      m_out_b = power_now ? seg_tab[m_dig] : 8'h00;
      m_in = (record > 27'd99_999_999) ? 99_999_999 : int'(record);
      m_valid = 1'b0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_num = m_val; m_bcd = to_bcd(m_val); m_valid = 1'b1; m_busy = 1'b0;
        end
      end else if (m_force || m_in != m_last) begin
        m_val = m_in; m_last = m_in; m_force = 1'b0; m_busy = 1'b1; m_rem = 28;
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("bcd_a", bus_a.bcd, m_bcd);
      chk("valid_a", 32'(bus_a.bcd_valid), 32'(m_valid));
      chk("seg_en_a", 32'(bus_a.seg_en), 32'(m_en_a));
      chk("seg_out_a", 32'(bus_a.seg_out), 32'(m_out_a));
      chk("bcd_b", bus_b.bcd, m_bcd);
      chk("seg_en_b", 32'(bus_b.seg_en), 32'(m_en_b));
      chk("seg_out_b", 32'(bus_b.seg_out), 32'(m_out_b));
    end
  end

  // Edge count (sample edge = 1) at which bcd_valid is seen; -1 on timeout.
  task automatic wait_valid(output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus_a.bcd_valid) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int k;
    logic [7:0] or_a, or_b, d1, d2;
    int bad_f6, lit_cnt;
    bit found;

    // Reset and record 0
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg_en", 32'(bus_a.seg_en), 32'h0);
    chk("rst_seg_out", 32'(bus_a.seg_out), 32'h0);
    chk("rst_bcd", bus_a.bcd, 32'h0);
    chk("rst_valid", 32'(bus_a.bcd_valid), 32'h0);
    rst = 1'b0;
    wait_valid(k);
    chk("t1_within30", 32'((k >= 1) && (k <= 30)), 32'h1);
    chk("t1_bcd", bus_a.bcd, 32'h0);
    or_a = '0; bad_f6 = 0;
    repeat (40) begin
      @(posedge clk); #1;
      or_a |= bus_a.seg_en;
      if (bus_a.seg_en != 8'h00 && bus_a.seg_out != 8'hFC) bad_f6++;
    end
    chk("t1_only_digit0", 32'(or_a), 32'h01);
    chk("t1_digit0_FC", 32'(bad_f6), 32'h0);

    // 12_345_678
    record = 27'd12_345_678;
    wait_valid(k);
    chk("t2_latency", 32'(k), 32'd29);
    chk("t2_bcd", bus_a.bcd, 32'h1234_5678);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (bus_a.seg_en == 8'h80) begin
        found = 1'b1;
        chk("t2_digit7", 32'(bus_a.seg_out), 32'h60);
      end
    end
    chk("t2_digit7_seen", 32'(found), 32'h1);

    // Over-range clamps to all nines
    record = 27'h7FF_FFFF;
    wait_valid(k);
    chk("t3_latency", 32'(k), 32'd29);
    chk("t3_bcd", bus_a.bcd, 32'h9999_9999);
    bad_f6 = 0; lit_cnt = 0;
    repeat (34) begin
      @(posedge clk); #1;
      if (bus_a.seg_en != 8'h00) begin
        lit_cnt++;
        if (bus_a.seg_out != 8'hF6) bad_f6++;
      end
    end
    chk("t3_all_F6", 32'(bad_f6), 32'h0);
    chk("t3_lit_cycles", 32'(lit_cnt), 32'd34);

    // 305: blanking on dut_a, all digits on dut_b
    record = 27'd305;
    wait_valid(k);
    chk("t4_bcd", bus_a.bcd, 32'h0000_0305);
    or_a = '0; or_b = '0; d1 = '0; d2 = '0;
    repeat (40) begin
      @(posedge clk); #1;
      or_a |= bus_a.seg_en;
      or_b |= bus_b.seg_en;
      if (bus_a.seg_en == 8'h02) d1 = bus_a.seg_out;
      if (bus_a.seg_en == 8'h04) d2 = bus_a.seg_out;
    end
    chk("t4_blank_or", 32'(or_a), 32'h07);
    chk("t4_noblank_or", 32'(or_b), 32'hFF);
    chk("t4_digit1", 32'(d1), 32'hFC);
    chk("t4_digit2", 32'(d2), 32'hF2);

    // 100, then 101 while shifting
    record = 27'd100;
    repeat (11) @(posedge clk);
    #1;
    record = 27'd101;
    wait_valid(k);
    chk("t5_first_bcd", bus_a.bcd, 32'h100);
    wait_valid(k);
    chk("t5_second_gap", 32'(k), 32'd29);
    chk("t5_second_bcd", bus_a.bcd, 32'h101);

    // Power off / on
    repeat (5) @(posedge clk);
    #1;
    power_now = 1'b0;
    @(posedge clk); #1;
    chk("t6_off_en_a", 32'(bus_a.seg_en), 32'h0);
    chk("t6_off_out_a", 32'(bus_a.seg_out), 32'h0);
    chk("t6_off_en_b", 32'(bus_b.seg_en), 32'h0);
    repeat (8) @(posedge clk);
    #1;
    power_now = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("t6_bcd_kept", bus_a.bcd, 32'h101);

    // Reset mid-conversion, held record reconverted
    record = 27'd4321;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t7_rst_bcd", bus_a.bcd, 32'h0);
    chk("t7_rst_en", 32'(bus_a.seg_en), 32'h0);
    rst = 1'b0;
    wait_valid(k);
    chk("t7_latency", 32'(k), 32'd29);
    chk("t7_bcd", bus_a.bcd, 32'h4321);

    repeat (10) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
